// File: rtl/fxp_pow_unit_if.sv
// Operand/result handshake bundle for fxp_pow_unit.
// master drives operands and consumes results; slave is the power unit.
interface fxp_pow_unit_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned EXP_W  = 4
);
  logic signed [DATA_W-1:0] in_data;
  logic        [EXP_W-1:0]  in_exp;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_exp, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_exp, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );
endinterface

// File: rtl/fxp_pow_unit.sv
// Fixed-point x^e by repeated rounded multiply, one multiply per cycle,
// with sticky saturation and ready/valid on both sides.
module fxp_pow_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned Q      = 15,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned EXP_W  = 4
) (
  input logic           clk,
  input logic           rst,
  fxp_pow_unit_if.slave bus
);
  localparam int unsigned PW    = OUT_W + DATA_W;
  localparam int unsigned RndSh = (Q > 0) ? Q - 1 : 0;
  localparam logic signed [PW-1:0] Rnd = (Q > 0) ? (PW'(1) << RndSh) : '0;
  localparam logic signed [PW-1:0] RMax = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW-1:0] RMin = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] AccMax = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] AccMin = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] One    = OUT_W'(1) << Q;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] x_q, x_d;
  logic signed [OUT_W-1:0]  acc_q, acc_d;
  logic                     sat_q, sat_d;
  logic        [EXP_W-1:0]  cnt_q, cnt_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rnd;

  // Full-width product cannot overflow PW bits, so the rounding add is safe.
  assign prod = PW'(acc_q) * PW'(x_q);
  assign rnd  = (prod + Rnd) >>> Q;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          x_d   = bus.in_data;
          sat_d = 1'b0;
          cnt_d = bus.in_exp - EXP_W'(1);
          if (bus.in_exp == '0) begin
            acc_d   = One;
            state_d = StDone;
          end else begin
            acc_d   = OUT_W'(bus.in_data);
            state_d = (bus.in_exp == EXP_W'(1)) ? StDone : StMul;
          end
        end
      end
      StMul: begin
        if (rnd > RMax) begin
          acc_d = AccMax;
          sat_d = 1'b1;
        end else if (rnd < RMin) begin
          acc_d = AccMin;
          sat_d = 1'b1;
        end else begin
          acc_d = rnd[OUT_W-1:0];
        end
        cnt_d = cnt_q - EXP_W'(1);
        if (cnt_q == EXP_W'(1)) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Result registers only change on entry to DONE so they persist past the handshake.
    if (state_q != StDone && state_d == StDone) begin
      out_data_d = acc_d;
      out_sat_d  = sat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      x_q        <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_fxp_pow_unit.sv
// Bench for fxp_pow_unit: default-parameter instance (a) and a Q=8/OUT_W=24 instance (b),
// checked against a plain-arithmetic power model.
module tb_fxp_pow_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fxp_pow_unit_if #(.DATA_W(16), .OUT_W(32), .EXP_W(4)) bus_a ();
  fxp_pow_unit_if #(.DATA_W(16), .OUT_W(24), .EXP_W(4)) bus_b ();

  fxp_pow_unit #(.DATA_W(16), .Q(15), .OUT_W(32), .EXP_W(4)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  fxp_pow_unit #(.DATA_W(16), .Q(8), .OUT_W(24), .EXP_W(4)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit sel, input bit v, input logic [15:0] d, input logic [3:0] e);
    if (sel) begin
      bus_b.in_valid = v; bus_b.in_data = d; bus_b.in_exp = e;
    end else begin
      bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_exp = e;
    end
  endtask

  task automatic set_ready(input bit sel, input bit r);
    if (sel) bus_b.out_ready = r;
    else     bus_a.out_ready = r;
  endtask

  function automatic longint rd_data(input bit sel);
    return sel ? longint'(bus_b.out_data) : longint'(bus_a.out_data);
  endfunction
  function automatic bit rd_valid(input bit sel);
    return sel ? bus_b.out_valid : bus_a.out_valid;
  endfunction
  function automatic bit rd_sat(input bit sel);
    return sel ? bus_b.out_sat : bus_a.out_sat;
  endfunction
  function automatic bit rd_in_ready(input bit sel);
    return sel ? bus_b.in_ready : bus_a.in_ready;
  endfunction

  // x^e with round-half-up after each multiply and clamping to ow-bit signed range.
  function automatic void model(input longint x, input int e, input int q, input int ow,
                                output longint res, output bit sat);
    longint mx, mn, half, p;
    mx   = (longint'(1) << (ow - 1)) - 1;
    mn   = -(longint'(1) << (ow - 1));
    half = (q > 0) ? (longint'(1) << (q - 1)) : 0;
    sat  = 1'b0;
    if (e == 0) begin
      res = longint'(1) << q;
      return;
    end
    res = x;
    for (int i = 1; i < e; i++) begin
      p = (res * x + half) >>> q;
      if (p > mx) begin
        p = mx; sat = 1'b1;
      end else if (p < mn) begin
        p = mn; sat = 1'b1;
      end
      res = p;
    end
  endfunction

  task automatic run_op(input bit sel, input logic [15:0] x, input int e, input int hold,
                        input string tag);
    int q, ow, lat, exp_lat;
    longint exp_res;
    bit exp_sat;
    q  = sel ? 8 : 15;
    ow = sel ? 24 : 32;
    model(longint'($signed(x)), e, q, ow, exp_res, exp_sat);
    lat = 0;
    while (!rd_in_ready(sel) && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, " in_ready idle"}, longint'(rd_in_ready(sel)), 1);
    set_ready(sel, 1'b0);
    set_in(sel, 1'b1, x, e[3:0]);
    tick();
    // Operands offered while busy must be ignored.
    set_in(sel, 1'b1, 16'($urandom), 4'($urandom));
    lat = 0;
    while (!rd_valid(sel) && lat < 40) begin
      tick();
      lat++;
    end
    // Result sampled high at edge T+max(1,e), i.e. visible just after edge T+max(1,e)-1.
    exp_lat = (e <= 1) ? 0 : e - 1;
    check({tag, " latency"}, longint'(lat), longint'(exp_lat));
    check({tag, " data"}, rd_data(sel), exp_res);
    check({tag, " sat"}, longint'(rd_sat(sel)), longint'(exp_sat));
    check({tag, " busy in_ready"}, longint'(rd_in_ready(sel)), 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold valid"}, longint'(rd_valid(sel)), 1);
      check({tag, " hold data"}, rd_data(sel), exp_res);
      check({tag, " hold in_ready"}, longint'(rd_in_ready(sel)), 0);
    end
    set_in(sel, 1'b0, '0, '0);
    set_ready(sel, 1'b1);
    tick();
    set_ready(sel, 1'b0);
    check({tag, " post valid"}, longint'(rd_valid(sel)), 0);
    check({tag, " post in_ready"}, longint'(rd_in_ready(sel)), 1);
    check({tag, " post data"}, rd_data(sel), exp_res);
    check({tag, " post sat"}, longint'(rd_sat(sel)), longint'(exp_sat));
  endtask

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    int seen;
    rst = 1'b1;
    set_in(1'b0, 1'b0, '0, '0);
    set_in(1'b1, 1'b0, '0, '0);
    set_ready(1'b0, 1'b0);
    set_ready(1'b1, 1'b0);
    repeat (3) tick();
    check("reset in_ready a", longint'(bus_a.in_ready), 0);
    check("reset in_ready b", longint'(bus_b.in_ready), 0);
    check("reset valid a", longint'(bus_a.out_valid), 0);
    check("reset data a", rd_data(1'b0), 0);
    check("reset sat a", longint'(bus_a.out_sat), 0);
    check("reset data b", rd_data(1'b1), 0);
    rst = 1'b0;
    #1;
    check("after reset in_ready a", longint'(bus_a.in_ready), 1);

    run_op(1'b0, 16'h4000, 2, 0, "half sq");
    run_op(1'b0, 16'h1234, 0, 0, "e0");
    run_op(1'b0, 16'h8000, 3, 0, "neg one cubed");
    run_op(1'b0, 16'd181, 2, 0, "round 181");
    run_op(1'b0, 16'd3, 2, 0, "round 3");
    run_op(1'b0, 16'hFF4B, 3, 0, "round -181");
    run_op(1'b0, 16'h4000, 2, 5, "backpressure");
    run_op(1'b1, 16'h7FFF, 4, 0, "sat b");
    run_op(1'b1, 16'h0100, 15, 0, "one e15 b");
    run_op(1'b1, 16'hFF00, 15, 1, "neg one e15 b");

    // Reset during the fourth MUL cycle discards the operation.
    set_in(1'b0, 1'b1, 16'h7000, 4'd15);
    tick();
    set_in(1'b0, 1'b0, '0, '0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst data", rd_data(1'b0), 0);
    check("midrst valid", longint'(bus_a.out_valid), 0);
    check("midrst sat", longint'(bus_a.out_sat), 0);
    check("midrst in_ready", longint'(bus_a.in_ready), 0);
    rst = 1'b0;
    #1;
    check("midrst in_ready after", longint'(bus_a.in_ready), 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_a.out_valid) seen++;
    end
    check("midrst no valid", longint'(seen), 0);
    run_op(1'b0, 16'h4000, 1, 0, "after midrst");

    for (int i = 0; i < 16; i++) begin
      run_op(1'b0, 16'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
             "rand a");
      run_op(1'b1, 16'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
             "rand b");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
